// File: rtl/fpmul_rr_scheduler.sv
// Round-robin scheduler that shares one pipelined FP multiplier among NUM_REQ requesters.
// An owner-tag pipe matched to the datapath latency steers each result into its requester's slot.
module fpmul_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 4,
   parameter int W       = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*W-1:0] req_a,
   input  logic [NUM_REQ*W-1:0] req_b,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 mul_valid,
   output logic [W-1:0]         mul_a,
   output logic [W-1:0]         mul_b,
   input  logic [W-1:0]         mul_res,
   input  logic                 mul_ovf,
   input  logic                 mul_unf,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [NUM_REQ*W-1:0] rsp_data,
   output logic [NUM_REQ*2-1:0] rsp_flags,
   input  logic [NUM_REQ-1:0]   rsp_ready,
   output logic                 idle
);

   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

   logic [NUM_REQ-1:0] busy_r;
   logic [NUM_REQ-1:0] eligible_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [NUM_REQ-1:0] cap_s;
   logic               grant_any_s;
   logic [IDW-1:0]     grant_id_s;
   logic [IDW-1:0]     rr_ptr_r;
   logic [IDW-1:0]     iss_id_r;
   logic [LATENCY-1:0] tag_v_r;
   logic [IDW-1:0]     tag_id_r [LATENCY];

   assign eligible_s = req_valid & ~busy_r;
   assign req_ready  = grant_s;
   assign idle       = ~|busy_r;

   // Arbiter: first eligible index from rr_ptr upward, explicit wrap for any NUM_REQ.
   always_comb begin
      logic [IDW:0] idx_s;
      grant_s     = '0;
      grant_any_s = 1'b0;
      grant_id_s  = '0;
      idx_s       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
         if (idx_s >= (IDW+1)'(NUM_REQ)) begin
            idx_s = idx_s - (IDW+1)'(NUM_REQ);
         end else begin
            idx_s = idx_s;
         end
         if (!grant_any_s && eligible_s[idx_s[IDW-1:0]]) begin
            grant_any_s                 = 1'b1;
            grant_id_s                  = idx_s[IDW-1:0];
            grant_s[idx_s[IDW-1:0]]     = 1'b1;
         end else begin
            grant_any_s = grant_any_s;
         end
      end
   end

   // Issue register: launch granted operands and move the pointer past the winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_valid <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         iss_id_r  <= '0;
         rr_ptr_r  <= '0;
      end else begin
         mul_valid <= grant_any_s;
         if (grant_any_s) begin
            mul_a    <= req_a[grant_id_s*W +: W];
            mul_b    <= req_b[grant_id_s*W +: W];
            iss_id_r <= grant_id_s;
            rr_ptr_r <= (grant_id_s == LAST_ID) ? '0 : grant_id_s + IDW'(1);
         end else begin
            mul_a    <= mul_a;
            mul_b    <= mul_b;
            iss_id_r <= iss_id_r;
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   // Owner-tag pipe; clearing it on reset drops whatever is still inside the datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v_r <= '0;
         for (int k = 0; k < LATENCY; k++) tag_id_r[k] <= '0;
      end else begin
         tag_v_r[0]  <= mul_valid;
         tag_id_r[0] <= iss_id_r;
         for (int k = 1; k < LATENCY; k++) begin
            tag_v_r[k]  <= tag_v_r[k-1];
            tag_id_r[k] <= tag_id_r[k-1];
         end
      end
   end

   // Decode which slot the result arriving this cycle belongs to.
   always_comb begin
      cap_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (tag_v_r[LATENCY-1] && (tag_id_r[LATENCY-1] == IDW'(i))) begin
            cap_s[i] = 1'b1;
         end else begin
            cap_s[i] = 1'b0;
         end
      end
   end

   // Result slots and per-requester busy flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         busy_r    <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cap_s[i]) begin
               rsp_valid[i]         <= 1'b1;
               rsp_data[i*W +: W]   <= mul_res;
               rsp_flags[i*2 +: 2]  <= {mul_ovf, mul_unf};
            end else if (rsp_valid[i] && rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end else begin
               rsp_valid[i] <= rsp_valid[i];
            end
            if (grant_s[i]) begin
               busy_r[i] <= 1'b1;
            end else if (rsp_valid[i] && rsp_ready[i]) begin
               busy_r[i] <= 1'b0;
            end else begin
               busy_r[i] <= busy_r[i];
            end
         end
      end
   end

   // Busy blocks regrant, so a capture can only ever hit an empty slot.
   a_no_overwrite: assert property (@(posedge clk) disable iff (rst) ((cap_s & rsp_valid) == '0));

endmodule

// File: tb/tb_fpmul_rr_scheduler.sv
// Directed bench for fpmul_rr_scheduler with a behavioural 4-stage FP multiplier model
// standing in for the shared datapath.
module tb_fpmul_rr_scheduler;
   localparam int N   = 4;
   localparam int LAT = 4;
   localparam int W   = 24;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0] req_a, req_b, rsp_data;
   logic [N*2-1:0] rsp_flags;
   logic           mul_valid, mul_ovf, mul_unf, idle;
   logic [W-1:0]   mul_a, mul_b, mul_res;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fpmul_rr_scheduler #(.NUM_REQ(N), .LATENCY(LAT), .W(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
      .mul_res(mul_res), .mul_ovf(mul_ovf), .mul_unf(mul_unf), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_ready(rsp_ready), .idle(idle)
   );

   // Reference FP multiply: returns {ovf, unf, result}.
   function automatic logic [25:0] fpmul_model(input logic [23:0] a, input logic [23:0] b);
      logic        s;
      int          es, e;
      logic [33:0] ma, mb, p;
      logic [15:0] fr;
      s  = a[23] ^ b[23];
      es = int'(a[22:16]) + int'(b[22:16]);
      ma = {17'd0, 1'b1, a[15:0]};
      mb = {17'd0, 1'b1, b[15:0]};
      p  = ma * mb;
      if (p[33]) begin
         fr = p[32:17];
         e  = es - 63 + 1;
      end else begin
         fr = p[31:16];
         e  = es - 63;
      end
      if (es > 190)     return {2'b10, s, 7'h7F, 16'hFFFF};
      else if (es < 63) return {2'b01, s, 23'd0};
      else              return {2'b00, s, 7'(e), fr};
   endfunction

   // Datapath model: result appears LAT cycles after mul_valid; not reset on purpose.
   logic         dp_v [LAT];
   logic [W-1:0] dp_a [LAT];
   logic [W-1:0] dp_b [LAT];
   always @(posedge clk) begin
      dp_v[0] <= mul_valid;
      dp_a[0] <= mul_a;
      dp_b[0] <= mul_b;
      for (int k = 1; k < LAT; k++) begin
         dp_v[k] <= dp_v[k-1];
         dp_a[k] <= dp_a[k-1];
         dp_b[k] <= dp_b[k-1];
      end
   end
   always_comb begin
      {mul_ovf, mul_unf, mul_res} = 26'd0;
      if (dp_v[LAT-1] === 1'b1) {mul_ovf, mul_unf, mul_res} = fpmul_model(dp_a[LAT-1], dp_b[LAT-1]);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic logic [W-1:0] op_a(input int i);
      return {1'b0, 7'(62 + i), 16'h4000};
   endfunction

   function automatic logic [W-1:0] op_b(input int i);
      return {1'b0, 7'd64, 16'(16'h2000 + i * 16'h0100)};
   endfunction

   task automatic load_ops();
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = op_a(i);
         req_b[i*W +: W] = op_b(i);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
      checks++; if (rsp_data !== 96'd0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
      checks++; if (rsp_flags !== 8'd0) begin errors++; $display("FAIL reset_rsp_flags got=%b exp=0", rsp_flags); end
      checks++; if ({mul_valid, mul_a, mul_b} !== 49'd0) begin errors++; $display("FAIL reset_mul got=%b/%h/%h exp=0", mul_valid, mul_a, mul_b); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
   endtask

   task automatic test_single();
      req_a[0 +: W] = 24'h3F8000;
      req_b[0 +: W] = 24'h400000;
      req_valid     = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
      step();
      req_valid = 4'b0000;
      checks++; if ({mul_valid, mul_a, mul_b} !== {1'b1, 24'h3F8000, 24'h400000})
         begin errors++; $display("FAIL single_issue got=%b/%h/%h exp=1/3f8000/400000", mul_valid, mul_a, mul_b); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy_idle got=%b exp=0", idle); end
      repeat (4) step();
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early got=%b exp=0000", rsp_valid); end
      step();
      checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
      checks++; if (rsp_data[0 +: W] !== 24'h408000) begin errors++; $display("FAIL single_rsp_data got=%h exp=408000", rsp_data[0 +: W]); end
      checks++; if (rsp_flags[1:0] !== 2'b00) begin errors++; $display("FAIL single_flags got=%b exp=00", rsp_flags[1:0]); end
      rsp_ready = 4'b0001;
      step();
      rsp_ready = 4'b0000;
      checks++; if ({rsp_valid, idle} !== 5'b00001) begin errors++; $display("FAIL single_drain got=%b/%b exp=0000/1", rsp_valid, idle); end
   endtask

   task automatic test_round_robin();
      int got [N];
      do_reset();
      load_ops();
      for (int i = 0; i < N; i++) got[i] = 0;
      rsp_ready = 4'b1111;
      req_valid = 4'b1111;
      #1;
      for (int c = 0; c < 24; c++) begin
         logic [N-1:0] eg, ev;
         eg = '0;
         ev = '0;
         if (c % 7 < 4) eg[c % 7] = 1'b1;
         if (c >= 6 && (c - 6) % 7 < 4) ev[(c - 6) % 7] = 1'b1;
         checks++; if (req_ready !== eg) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, eg); end
         checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, ev); end
         for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
               logic [25:0] m;
               got[i]++;
               m = fpmul_model(op_a(i), op_b(i));
               checks++; if (rsp_data[i*W +: W] !== m[23:0])
                  begin errors++; $display("FAIL rr_rsp_data c=%0d i=%0d got=%h exp=%h", c, i, rsp_data[i*W +: W], m[23:0]); end
            end
         end
         step();
      end
      for (int i = 0; i < N; i++) begin
         checks++; if (got[i] !== 3) begin errors++; $display("FAIL rr_count i=%0d got=%0d exp=3", i, got[i]); end
      end
      req_valid = '0;
      repeat (8) step();
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rr_idle got=%b exp=1", idle); end
   endtask

   task automatic test_backpressure();
      int  ng [N];
      bit  regrant;
      do_reset();
      load_ops();
      for (int i = 0; i < N; i++) ng[i] = 0;
      rsp_ready = 4'b1101;
      req_valid = 4'b1111;
      #1;
      for (int c = 0; c < 20; c++) begin
         logic [25:0] m;
         for (int i = 0; i < N; i++) if (req_ready[i]) ng[i]++;
         checks++; if (rsp_valid[1] !== (c >= 7)) begin errors++; $display("FAIL bp_valid1 c=%0d got=%b exp=%b", c, rsp_valid[1], c >= 7); end
         if (c >= 7) begin
            m = fpmul_model(op_a(1), op_b(1));
            checks++; if (rsp_data[W +: W] !== m[23:0]) begin errors++; $display("FAIL bp_data1 c=%0d got=%h exp=%h", c, rsp_data[W +: W], m[23:0]); end
         end
         step();
      end
      checks++; if (ng[0] !== 3) begin errors++; $display("FAIL bp_grants0 got=%0d exp=3", ng[0]); end
      checks++; if (ng[1] !== 1) begin errors++; $display("FAIL bp_grants1 got=%0d exp=1", ng[1]); end
      checks++; if (ng[2] !== 3) begin errors++; $display("FAIL bp_grants2 got=%0d exp=3", ng[2]); end
      checks++; if (ng[3] !== 3) begin errors++; $display("FAIL bp_grants3 got=%0d exp=3", ng[3]); end
      rsp_ready = 4'b1111;
      regrant   = 1'b0;
      #1;
      for (int c = 0; c < 10 && !regrant; c++) begin
         if (req_ready[1]) regrant = 1'b1;
         else step();
      end
      checks++; if (regrant !== 1'b1) begin errors++; $display("FAIL bp_regrant1 got=%b exp=1 within 10 cycles", regrant); end
      req_valid = '0;
      repeat (10) step();
   endtask

   task automatic test_fairness();
      int gc [$];
      do_reset();
      load_ops();
      rsp_ready = 4'b1111;
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL fair_setup got=%b exp=0100", req_ready); end
      step();
      req_valid = 4'b0000;
      repeat (8) step();
      req_valid = 4'b1001;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL fair_wrap_first got=%b exp=1000", req_ready); end
      step();
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_wrap_second got=%b exp=0001", req_ready); end
      step();
      req_valid = 4'b0000;
      repeat (8) step();
      req_valid = 4'b0100;
      #1;
      for (int c = 0; c < 30; c++) begin
         if (req_ready[2]) gc.push_back(c);
         step();
      end
      req_valid = '0;
      checks++; if (gc.size() !== 5) begin errors++; $display("FAIL fair_count got=%0d exp=5", gc.size()); end
      for (int k = 1; k < gc.size() && k < 4; k++) begin
         checks++; if (gc[k] - gc[k-1] !== LAT + 3)
            begin errors++; $display("FAIL fair_interval k=%0d got=%0d exp=%0d", k, gc[k] - gc[k-1], LAT + 3); end
      end
      repeat (8) step();
   endtask

   task automatic test_reset_midflight();
      do_reset();
      load_ops();
      req_valid = 4'b0111;
      #1;
      for (int c = 0; c < 3; c++) begin
         logic [N-1:0] eg;
         eg    = '0;
         eg[c] = 1'b1;
         checks++; if (req_ready !== eg) begin errors++; $display("FAIL mid_grant c=%0d got=%b exp=%b", c, req_ready, eg); end
         step();
      end
      req_valid = '0;
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         checks++; if ({rsp_valid, idle, mul_valid} !== 6'b000010)
            begin errors++; $display("FAIL mid_quiet c=%0d got=%b/%b/%b exp=0000/1/0", c, rsp_valid, idle, mul_valid); end
         step();
      end
      req_valid = 4'b1110;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready); end
      step();
      req_valid = '0;
      rsp_ready = 4'b1111;
      repeat (8) step();
   endtask

   task automatic test_flags();
      do_reset();
      req_a[0*W +: W] = 24'h7F0000;
      req_b[0*W +: W] = 24'h7F0000;
      req_a[3*W +: W] = 24'h010000;
      req_b[3*W +: W] = 24'h010000;
      req_valid = 4'b1001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flags_grant0 got=%b exp=0001", req_ready); end
      step();
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL flags_grant3 got=%b exp=1000", req_ready); end
      step();
      req_valid = '0;
      repeat (5) step();
      for (int r = 0; r < 2; r++) begin
         checks++; if (rsp_valid !== 4'b1001) begin errors++; $display("FAIL flags_valid r=%0d got=%b exp=1001", r, rsp_valid); end
         checks++; if (rsp_flags[1:0] !== 2'b10) begin errors++; $display("FAIL flags_ovf r=%0d got=%b exp=10", r, rsp_flags[1:0]); end
         checks++; if (rsp_flags[7:6] !== 2'b01) begin errors++; $display("FAIL flags_unf r=%0d got=%b exp=01", r, rsp_flags[7:6]); end
         step();
         step();
      end
      rsp_ready = 4'b1111;
      step();
      checks++; if ({rsp_valid, idle} !== 5'b00001) begin errors++; $display("FAIL flags_drain got=%b/%b exp=0000/1", rsp_valid, idle); end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_fairness();
      test_reset_midflight();
      test_flags();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
